// File: rtl/arm_pkg.sv
// Shared types and constants for the memory stage and its SRAM controller.
package arm_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LO   = 2'd1,
    HI   = 2'd2,
    DONE = 2'd3
  } mem_state_t;

  localparam int MEM_BASE_DEF = 1024;
  localparam int SRAM_DW      = 16;
  localparam int SRAM_AW      = 18;
  localparam int SRAM_WORD_AW = SRAM_AW - 1;

endpackage

// File: rtl/sram_ctrl.sv
// Splits a 32-bit load/store into two 16-bit SRAM halfword accesses; optional range check under MEM_STAGE_ADDR_CHECK_EN.
// Latency: 2*(SRAM_WAIT+1)+1 cycles with ready low, then one DONE cycle with ready high.
// Backpressure: ready is low from request acceptance until DONE; request inputs must be held stable meanwhile.
module sram_ctrl
  import arm_pkg::*;
#(
  parameter int SRAM_WAIT = 1,
  parameter int MEM_BASE  = MEM_BASE_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [31:0]          addr,
  input  logic [31:0]          wdata,
  input  logic                 rd_en,
  input  logic                 wr_en,
  output logic                 ready,
  output logic [31:0]          rdata,
  output logic [SRAM_AW-1:0]   sram_addr,
  output logic [SRAM_DW-1:0]   sram_dq_out,
  output logic                 sram_dq_oe,
  input  logic [SRAM_DW-1:0]   sram_dq_in,
  output logic                 sram_we_n,
  output logic                 addr_err
);

  localparam logic [31:0] BASE = 32'(MEM_BASE);
  localparam logic [2:0]  LAST = 3'(SRAM_WAIT);

  mem_state_t              state;
  logic [2:0]              cnt;
  logic [SRAM_WORD_AW-1:0] word;
  logic                    req;
  logic                    is_store;
  logic                    last;
  logic                    bad_addr;

  assign req      = rd_en | wr_en;
  assign is_store = wr_en;
  assign last     = (cnt == LAST);
  // Word index wraps modulo 2^17; byte-lane bits are discarded.
  assign word     = SRAM_WORD_AW'((addr - BASE) >> 2);

`ifdef MEM_STAGE_ADDR_CHECK_EN
  logic [31:0] offset;
  assign offset   = addr - BASE;
  assign bad_addr = (addr < BASE) || ((offset >> 19) != 32'd0);

  always_ff @(posedge clk) begin
    if (!reset) begin
      addr_err <= 1'b0;
    end else if (state == IDLE && req && bad_addr) begin
      addr_err <= 1'b1;
    end
  end
`else
  assign bad_addr = 1'b0;
  assign addr_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      rdata <= 32'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 3'd0;
          if (req) begin
            if (bad_addr) begin
              state <= DONE;
              if (!is_store) rdata <= 32'd0;
            end else begin
              state <= LO;
            end
          end
        end
        LO: begin
          if (last) begin
            cnt   <= 3'd0;
            state <= HI;
            if (!is_store) rdata[15:0] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        HI: begin
          if (last) begin
            cnt   <= 3'd0;
            state <= DONE;
            if (!is_store) rdata[31:16] <= sram_dq_in;
          end else begin
            cnt <= cnt + 3'd1;
          end
        end
        default: begin
          cnt   <= 3'd0;
          state <= IDLE;
        end
      endcase
    end
  end

  always_comb begin
    ready       = 1'b0;
    sram_addr   = '0;
    sram_dq_out = '0;
    sram_dq_oe  = 1'b0;
    sram_we_n   = 1'b1;
    case (state)
      IDLE: ready = !req;
      LO: begin
        sram_addr = {word, 1'b0};
        if (is_store) begin
          sram_dq_out = wdata[15:0];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      HI: begin
        sram_addr = {word, 1'b1};
        if (is_store) begin
          sram_dq_out = wdata[31:16];
          sram_dq_oe  = 1'b1;
          sram_we_n   = 1'b0;
        end
      end
      default: ready = 1'b1;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Pipeline memory stage: SRAM controller plus WB pipeline register; MEM_STAGE_ADDR_CHECK_EN enables address range checking.
// Latency: one cycle for non-memory ops; loads/stores freeze upstream 2*(SRAM_WAIT+1)+1 cycles.
// Backpressure: ready low freezes upstream and injects a bubble (WB enables cleared, data held).
module mem_stage
  import arm_pkg::*;
#(
  parameter int SRAM_WAIT = 1,
  parameter int MEM_BASE  = MEM_BASE_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] ALU_result,
  input  logic [31:0] VAL_RM,
  input  logic        MEM_R_EN,
  input  logic        MEM_W_EN,
  input  logic        WB_EN,
  input  logic [3:0]  Dest,
  output logic        ready,
  output logic        WB_WB_EN,
  output logic        WB_MEM_R_EN,
  output logic [31:0] WB_ALU_result,
  output logic [31:0] WB_MEM_result,
  output logic [3:0]  WB_Dest,
  output logic [17:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_out,
  output logic        SRAM_DQ_oe,
  input  logic [15:0] SRAM_DQ_in,
  output logic        SRAM_WE_N,
  output logic        addr_err
);

  logic [31:0] rdata;

  sram_ctrl #(
    .SRAM_WAIT (SRAM_WAIT),
    .MEM_BASE  (MEM_BASE)
  ) u_sram_ctrl (
    .clk         (clk),
    .reset       (reset),
    .addr        (ALU_result),
    .wdata       (VAL_RM),
    .rd_en       (MEM_R_EN),
    .wr_en       (MEM_W_EN),
    .ready       (ready),
    .rdata       (rdata),
    .sram_addr   (SRAM_ADDR),
    .sram_dq_out (SRAM_DQ_out),
    .sram_dq_oe  (SRAM_DQ_oe),
    .sram_dq_in  (SRAM_DQ_in),
    .sram_we_n   (SRAM_WE_N),
    .addr_err    (addr_err)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      WB_WB_EN      <= 1'b0;
      WB_MEM_R_EN   <= 1'b0;
      WB_ALU_result <= 32'd0;
      WB_MEM_result <= 32'd0;
      WB_Dest       <= 4'd0;
    end else if (ready) begin
      WB_WB_EN      <= WB_EN;
      // A combined read+write request is a store, so it is not flagged as a load.
      WB_MEM_R_EN   <= MEM_R_EN & ~MEM_W_EN;
      WB_ALU_result <= ALU_result;
      WB_MEM_result <= rdata;
      WB_Dest       <= Dest;
    end else begin
      WB_WB_EN    <= 1'b0;
      WB_MEM_R_EN <= 1'b0;
    end
  end

endmodule
